// File: rtl/btn_debounce.sv
// Per-button 2-FF synchroniser, debouncer and press/release/long-press pulse generator.
// Latency: DEBOUNCE_CYCLES+2 edges from a raw level change to btn_level; no backpressure, pulses are fire-and-forget.
module btn_debounce #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int HOLD_CYCLES     = 12000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [DW-1:0] DB_TERM  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic          sync1;
        logic          sync2;
        logic          stable;
        logic [DW-1:0] db_cnt;
        logic [HW-1:0] hold_cnt;
        logic          press_q;
        logic          release_q;
        logic          long_q;

        always_ff @(posedge CLK) begin
            if (RST) begin
                sync1     <= 1'b0;
                sync2     <= 1'b0;
                stable    <= 1'b0;
                db_cnt    <= '0;
                hold_cnt  <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                sync1     <= btn_raw[i];
                sync2     <= sync1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;

                // Any return to the stable value restarts the count, so short glitches never land.
                if (sync2 == stable) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_TERM) begin
                    stable    <= sync2;
                    db_cnt    <= '0;
                    press_q   <= sync2;
                    release_q <= ~sync2;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end

                // Saturating at HOLD_MAX is what limits btn_long to one pulse per press.
                if (!stable) begin
                    hold_cnt <= '0;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + HW'(1);
                    long_q   <= (hold_cnt == HOLD_PRE);
                end
            end
        end

        assign btn_level[i]   = stable;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_long[i]    = long_q;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
module tb_btn_debounce;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] btn_raw = 3'b000;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [2:0] btn_release;
    logic [2:0] btn_long;

    int n_cmp = 0;
    int n_bad = 0;

    btn_debounce #(
        .N_BTN(3),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_long(btn_long)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [2:0] raw;
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rel;
        logic [2:0] lng;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [2:0] raw, input logic [2:0] lvl,
                       input logic [2:0] prs, input logic [2:0] rel, input logic [2:0] lng,
                       input int reps);
        vec_t v;
        v.rst = r; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.lng = lng;
        for (int k = 0; k < reps; k++) tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [2:0] got, input logic [2:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s[%0d] got %b want %b", name, idx, got, want);
        end
    endtask

    // Drive inputs, take one edge, then compare all outputs just after the edge.
    task automatic cyc(input string tag, input int idx, input logic r, input logic [2:0] raw,
                       input logic [2:0] lvl, input logic [2:0] prs,
                       input logic [2:0] rel, input logic [2:0] lng);
        RST = r;
        btn_raw = raw;
        @(posedge CLK);
        #1;
        chk({tag, ".level"},   idx, btn_level,   lvl);
        chk({tag, ".press"},   idx, btn_press,   prs);
        chk({tag, ".release"}, idx, btn_release, rel);
        chk({tag, ".long"},    idx, btn_long,    lng);
    endtask

    initial begin
        // Reset with all buttons held, then press on the 6th edge after release of RST.
        add(1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3);
        add(0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 5);
        add(0, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 1);
        add(0, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1);
        add(1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1);
        // Glitch of 3 cycles is swallowed; 4 cycles gets through and then releases.
        add(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3);
        add(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 6);
        add(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 4);
        add(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1);
        add(0, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 1);
        add(0, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3);
        add(0, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 1);
        add(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1);
        // Simultaneous channels: 000->101, then 101->011; channel 0 reaches its long press.
        add(0, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 5);
        add(0, 3'b101, 3'b101, 3'b101, 3'b000, 3'b000, 1);
        add(0, 3'b101, 3'b101, 3'b000, 3'b000, 3'b000, 1);
        add(0, 3'b011, 3'b101, 3'b000, 3'b000, 3'b000, 5);
        add(0, 3'b011, 3'b011, 3'b010, 3'b100, 3'b000, 1);
        add(0, 3'b011, 3'b011, 3'b000, 3'b000, 3'b000, 2);
        add(0, 3'b011, 3'b011, 3'b000, 3'b000, 3'b001, 1);
        add(0, 3'b011, 3'b011, 3'b000, 3'b000, 3'b000, 1);
        add(1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1);

        foreach (tbl[i])
            cyc("tbl", i, tbl[i].rst, tbl[i].raw, tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].lng);

        // Bounce on channel 1: 1,0,1,0 then held; one press 6 edges after the final rise.
        for (int k = 0; k < 4; k++)
            cyc("bounce", k, 0, (k % 2 == 0) ? 3'b010 : 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int k = 1; k <= 8; k++)
            cyc("bounce_hold", k, 0, 3'b010, (k >= 6) ? 3'b010 : 3'b000,
                (k == 6) ? 3'b010 : 3'b000, 3'b000, 3'b000);
        cyc("rst_a", 0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

        // Long press on channel 2: press at 6, long at 16 only, release 6 edges after the fall.
        for (int k = 1; k <= 40; k++)
            cyc("long_hold", k, 0, 3'b100, (k >= 6) ? 3'b100 : 3'b000,
                (k == 6) ? 3'b100 : 3'b000, 3'b000, (k == 16) ? 3'b100 : 3'b000);
        for (int k = 1; k <= 8; k++)
            cyc("long_rel", k, 0, 3'b000, (k < 6) ? 3'b100 : 3'b000, 3'b000,
                (k == 6) ? 3'b100 : 3'b000, 3'b000);
        cyc("rst_b", 0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

        // Reset two edges before the long press is due: no long, press re-fires after reset.
        for (int k = 1; k <= 13; k++)
            cyc("mid_hold", k, 0, 3'b100, (k >= 6) ? 3'b100 : 3'b000,
                (k == 6) ? 3'b100 : 3'b000, 3'b000, 3'b000);
        for (int k = 14; k <= 15; k++)
            cyc("mid_rst", k, 1, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int k = 1; k <= 12; k++)
            cyc("post_rst", k, 0, 3'b100, (k >= 6) ? 3'b100 : 3'b000,
                (k == 6) ? 3'b100 : 3'b000, 3'b000, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
